// File: rtl/bist_engine.sv
// Self-sequencing BIST engine for the arithmetic controller datapath
// (A = K1*x1 + K2*x2, B = v*t + c). It drives NUM_VECTORS operand sets,
// computes golden results, aligns them to the DUT latency and scores
// every returned result.
module bist_engine #(
  parameter int          W           = 8,
  parameter int          RW          = 16,
  parameter int          K1          = 3,
  parameter int          K2          = 5,
  parameter int          NUM_VECTORS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] SEED        = 32'hACE1_2025
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pattern_mode,
  output logic [W-1:0]  x1,
  output logic [W-1:0]  x2,
  output logic [W-1:0]  v,
  output logic [W-1:0]  t,
  output logic [W-1:0]  c,
  input  logic [RW-1:0] a_dut,
  input  logic [RW-1:0] b_dut,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   err_count,
  output logic [15:0]   first_fail_idx,
  output logic [1:0]    fail_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

  // One entry of the golden delay line.
  typedef struct packed {
    logic          vld;
    logic [15:0]   idx;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
  } tagT;

  localparam logic [31:0] SEED_EFF   = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  DRAIN_LAST = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
  localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  stateT              state, stateNext;
  logic [15:0]        idx;
  logic [31:0]        lfsr;
  logic               modeLat;
  logic [2:0]         drainCnt;
  logic [4:0][W-1:0]  ops;

  logic               accept, lastVec, loadOps, clearOps, loadMode;
  logic [15:0]        loadIdx;
  logic [31:0]        loadLfsr, nextLfsr;
  logic [4:0][W-1:0]  opSel;

  tagT                tagNow, tagCmp;
  logic               aBad, bBad, mismatch;
  logic [15:0]        errNext;

  // Operand k of an LFSR vector: state rotated right by 6k, low W bits.
  function automatic logic [W-1:0] lfsrOp(input logic [31:0] s, input int k);
    return W'((s >> (6 * k)) | (s << (32 - 6 * k)));
  endfunction

  assign x1 = ops[0];
  assign x2 = ops[1];
  assign v  = ops[2];
  assign t  = ops[3];
  assign c  = ops[4];

  assign accept  = (state == IDLE) && start;
  assign lastVec = (idx == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state and status outputs.
  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) stateNext = RUN;
      RUN: begin
        busy = 1'b1;
        if (lastVec) stateNext = (LATENCY > 0) ? DRAIN : DONE;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drainCnt == DRAIN_LAST) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Next operand set: vector 0 on an accepted start, else the following vector.
  always_comb begin
    nextLfsr = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
    loadLfsr = (state == IDLE) ? SEED_EFF : nextLfsr;
    loadIdx  = (state == IDLE) ? 16'd0 : idx + 16'd1;
    loadMode = (state == IDLE) ? pattern_mode : modeLat;
    loadOps  = accept || ((state == RUN) && !lastVec);
    // DRAIN keeps the last vector on the bus; everything else outside RUN is 0.
    clearOps = (stateNext == IDLE) || (stateNext == DONE);
    for (int k = 0; k < 5; k++)
      opSel[k] = loadMode ? loadIdx[W-1:0] : lfsrOp(loadLfsr, k);
  end

  // Vector sequencing: index, LFSR, latched mode, drain counter, operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      lfsr     <= SEED_EFF;
      modeLat  <= 1'b0;
      drainCnt <= '0;
      ops      <= '0;
    end else begin
      if (loadOps) begin
        idx  <= loadIdx;
        lfsr <= loadLfsr;
        ops  <= opSel;
      end else if (clearOps) begin
        ops <= '0;
      end
      if (accept) modeLat <= pattern_mode;
      drainCnt <= (state == DRAIN) ? drainCnt + 3'd1 : 3'd0;
    end
  end

  // Golden results from the registered operands. Low RW bits of a sum of
  // products depend only on the low RW bits of the terms, so RW-wide math
  // equals full-width math truncated to RW.
  always_comb begin
    tagNow     = '0;
    tagNow.vld = (state == RUN);
    tagNow.idx = idx;
    tagNow.a   = RW'(K1) * RW'(ops[0]) + RW'(K2) * RW'(ops[1]);
    tagNow.b   = RW'(ops[2]) * RW'(ops[3]) + RW'(ops[4]);
  end

  generate
    if (LATENCY == 0) begin : gNoDelay
      assign tagCmp = tagNow;
    end else begin : gDelay
      tagT pipe [0:LATENCY-1];
      // Delay line aligning golden values with the DUT pipeline.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
        end else begin
          pipe[0] <= tagNow;
          for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
        end
      end
      assign tagCmp = pipe[LATENCY-1];
    end
  endgenerate

  // Compare against the aligned golden entry.
  always_comb begin
    aBad     = tagCmp.vld && (a_dut != tagCmp.a);
    bBad     = tagCmp.vld && (b_dut != tagCmp.b);
    mismatch = aBad || bBad;
    errNext  = (mismatch && (err_count != 16'hFFFF)) ? err_count + 16'd1 : err_count;
  end

  // Scoreboard: error count, first failing index, sticky mask and verdict.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      err_count      <= '0;
      first_fail_idx <= '0;
      fail_mask      <= '0;
      pass           <= 1'b0;
    end else begin
      if (mismatch) begin
        err_count <= errNext;
        fail_mask <= fail_mask | {bBad, aBad};
        if (err_count == 16'd0) first_fail_idx <= tagCmp.idx;
      end
      // The final vector's compare lands on the edge entering DONE, so the
      // verdict uses the post-compare count.
      if ((state != DONE) && (stateNext == DONE)) pass <= (errNext == 16'd0);
    end
  end

endmodule
